// File: rtl/if_fetch_sequencer.sv
// rtl/if_fetch_sequencer.sv - fetch-stage PC owner and single-outstanding imem requester
// Redirects from EX always win; a one-word hold buffer absorbs a response that lands during a stall.
module if_fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCTargetE,
    input  logic        PCSrcE,
    input  logic        StallF,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF,
    output logic        MisalignF
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        req_valid_q, req_valid_d;

    logic        handshake;
    logic        deliver;
    logic [31:0] deliver_data;

    assign handshake = req_valid_q & imem_req_ready;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        hold_data_d  = hold_data_q;
        instr_d      = instr_q;
        pcf_d        = pcf_q;
        pcplus4_d    = pcplus4_q;
        valid_d      = valid_q;
        misalign_d   = 1'b0;
        deliver      = 1'b0;
        deliver_data = imem_rsp_data;

        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (handshake) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (StallF) begin
                        hold_data_d = imem_rsp_data;
                        state_d     = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                if (!StallF) begin
                    deliver      = 1'b1;
                    deliver_data = hold_data_q;
                    state_d      = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        if (PCSrcE) begin
            fetch_pc_d = {PCTargetE[31:2], 2'b00};
            misalign_d = |PCTargetE[1:0];
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            // Any request already accepted is wrong-path; its beat must be swallowed before refetching.
            case (state_q)
                REQ:     state_d = handshake ? DRAIN : REQ;
                WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
                DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else if (deliver) begin
            instr_d   = deliver_data;
            pcf_d     = req_pc_q;
            pcplus4_d = req_pc_q + 32'd4;
            valid_d   = 1'b1;
        end else if (!StallF) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            hold_data_q <= NOP_INSTR;
            instr_q     <= NOP_INSTR;
            pcf_q       <= 32'h0000_0000;
            pcplus4_q   <= 32'h0000_0004;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            hold_data_q <= hold_data_d;
            instr_q     <= instr_d;
            pcf_q       <= pcf_d;
            pcplus4_q   <= pcplus4_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign InstrF         = instr_q;
    assign PCF            = pcf_q;
    assign PCPlus4F       = pcplus4_q;
    assign InstrValidF    = valid_q;
    assign MisalignF      = misalign_q;

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// tb/tb_if_fetch_sequencer.sv - randomized self-checking bench for if_fetch_sequencer
// An imem model answers handshakes; a stream scoreboard predicts every delivered PC from redirects.
`timescale 1ns/1ps
module tb_if_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PCTargetE = 32'h0;
    logic        PCSrcE = 1'b0;
    logic        StallF = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;
    logic        MisalignF;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .PCTargetE      (PCTargetE),
        .PCSrcE         (PCSrcE),
        .StallF         (StallF),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .InstrValidF    (InstrValidF),
        .MisalignF      (MisalignF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    // imem model: one response per handshake after mem_lat cycles (0 = random 1..3)
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        hs_s = 1'b0;
    logic [31:0] hs_addr_s = 32'h0;

    always @(negedge clk) begin
        hs_s      = imem_req_valid && imem_req_ready && !rst;
        hs_addr_s = imem_req_addr;
    end

    always begin
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (hs_s) begin
                mem_busy = 1'b1;
                mem_addr = hs_addr_s;
                mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                    mem_busy       = 1'b0;
                end
            end
        end
    end

    // Stream scoreboard: the delivered PC sequence is sequential words, restarted at each aligned redirect target
    logic [31:0] exp_pc = 32'h0;
    logic        have_prev = 1'b0;
    logic        p_stall, p_redir, p_req_valid, p_ready, p_valid;
    logic [31:0] p_tgt, p_addr, p_pcf, p_instr, p_pc4;
    logic [31:0] hs_log[$];
    logic [31:0] deliv_log[$];

    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
            exp_pc    = 32'h0;
            hs_log.delete();
            deliv_log.delete();
        end else begin
            if (have_prev) begin
                if (p_redir) begin
                    n_checks++;
                    if (InstrValidF !== 1'b0 || InstrF !== NOP) begin
                        n_errors++;
                        $display("FAIL flush: valid=%0b instr=%h, required valid=0 instr=%h", InstrValidF, InstrF, NOP);
                    end
                    n_checks++;
                    if (MisalignF !== (p_tgt[1:0] != 2'b00)) begin
                        n_errors++;
                        $display("FAIL misalign_flag: got %0b for target %h", MisalignF, p_tgt);
                    end
                    exp_pc = {p_tgt[31:2], 2'b00};
                end else begin
                    n_checks++;
                    if (MisalignF !== 1'b0) begin
                        n_errors++;
                        $display("FAIL misalign_idle: got %0b, required 0", MisalignF);
                    end
                    if (p_stall) begin
                        n_checks++;
                        if (InstrValidF !== p_valid || PCF !== p_pcf || InstrF !== p_instr || PCPlus4F !== p_pc4) begin
                            n_errors++;
                            $display("FAIL stall_hold: valid=%0b pc=%h instr=%h pc4=%h, required %0b %h %h %h",
                                     InstrValidF, PCF, InstrF, PCPlus4F, p_valid, p_pcf, p_instr, p_pc4);
                        end
                    end else if (InstrValidF === 1'b1) begin
                        n_checks++;
                        if (PCF !== exp_pc || InstrF !== mem_word(exp_pc) || PCPlus4F !== exp_pc + 32'd4) begin
                            n_errors++;
                            $display("FAIL deliver: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                     PCF, InstrF, PCPlus4F, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                        end
                        deliv_log.push_back(PCF);
                        exp_pc = exp_pc + 32'd4;
                    end else begin
                        n_checks++;
                        if (InstrF !== NOP) begin
                            n_errors++;
                            $display("FAIL bubble: instr=%h, required %h", InstrF, NOP);
                        end
                    end
                end
                if (p_req_valid && !p_ready && !p_redir) begin
                    n_checks++;
                    if (imem_req_valid !== 1'b1 || imem_req_addr !== p_addr) begin
                        n_errors++;
                        $display("FAIL req_stable: valid=%0b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, p_addr);
                    end
                end
            end
            n_checks++;
            if (imem_req_valid && (mem_busy || imem_rsp_valid)) begin
                n_errors++;
                $display("FAIL one_outstanding: request valid at %h while a response is pending", imem_req_addr);
            end
            if (imem_req_valid && imem_req_ready) hs_log.push_back(imem_req_addr);
            have_prev   = 1'b1;
            p_stall     = StallF;
            p_redir     = PCSrcE;
            p_tgt       = PCTargetE;
            p_req_valid = imem_req_valid;
            p_ready     = imem_req_ready;
            p_addr      = imem_req_addr;
            p_valid     = InstrValidF;
            p_pcf       = PCF;
            p_instr     = InstrF;
            p_pc4       = PCPlus4F;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        StallF         = 1'b0;
        PCSrcE         = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (InstrF !== NOP || PCF !== 32'h0 || PCPlus4F !== 32'h4 || InstrValidF !== 1'b0 || MisalignF !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: instr=%h pc=%h pc4=%h valid=%0b mis=%0b req=%0b", InstrF, PCF, PCPlus4F, InstrValidF, MisalignF, imem_req_valid);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL boot_no_req: req_valid=%0b, required 0", imem_req_valid);
        end
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL first_req: valid=%0b addr=%h, required 1 00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] got;
        for (int i = 0; i < 40 && deliv_log.size() < 3; i++) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            got = (hs_log.size() > i) ? hs_log[i] : 32'hDEAD_DEAD;
            n_checks++;
            if (got !== 32'(4 * i)) begin
                n_errors++;
                $display("FAIL seq_req%0d: addr=%h, required %h", i, got, 32'(4 * i));
            end
            got = (deliv_log.size() > i) ? deliv_log[i] : 32'hDEAD_DEAD;
            n_checks++;
            if (got !== 32'(4 * i)) begin
                n_errors++;
                $display("FAIL seq_deliver%0d: pc=%h, required %h", i, got, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h8) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL stall_hs_timeout: no handshake to 00000008 within 60 cycles");
        end
        cyc();
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (PCF !== 32'h4 || imem_req_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_frozen%0d: pc=%h req_valid=%0b, required 00000004 0", i, PCF, imem_req_valid);
            end
            cyc();
        end
        StallF = 1'b0;
        cyc();
        @(negedge clk);
        n_checks++;
        if (InstrValidF !== 1'b1 || PCF !== 32'h8 || InstrF !== mem_word(32'h8) || PCPlus4F !== 32'hC) begin
            n_errors++;
            $display("FAIL stall_release: valid=%0b pc=%h instr=%h pc4=%h, required 1 00000008 %h 0000000c", InstrValidF, PCF, InstrF, PCPlus4F, mem_word(32'h8));
        end
        #1;
        n_checks++;
        if (deliv_log.size() != 3) begin
            n_errors++;
            $display("FAIL stall_no_loss: %0d deliveries, required 3", deliv_log.size());
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        int idx;
        logic [31:0] got;
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hC) found = 1;
        end
        #1;
        idx = hs_log.size();
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL redir_hs_timeout: no handshake to 0000000c within 80 cycles");
        end
        cyc();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        cyc();
        PCSrcE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (InstrValidF !== 1'b0 || InstrF !== NOP) begin
            n_errors++;
            $display("FAIL redir_bubble: valid=%0b instr=%h, required 0 %h", InstrValidF, InstrF, NOP);
        end
        for (int i = 0; i < 30 && InstrValidF !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (InstrValidF !== 1'b1 || PCF !== 32'h100 || InstrF !== mem_word(32'h100)) begin
            n_errors++;
            $display("FAIL redir_target: valid=%0b pc=%h instr=%h, required 1 00000100 %h", InstrValidF, PCF, InstrF, mem_word(32'h100));
        end
        #1;
        got = (hs_log.size() > idx) ? hs_log[idx] : 32'hDEAD_DEAD;
        n_checks++;
        if (got !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_next_req: addr=%h, required 00000100", got);
        end
        got = (deliv_log.size() > 3) ? deliv_log[3] : 32'hDEAD_DEAD;
        n_checks++;
        if (got !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_discard: fourth delivery pc=%h, required 00000100", got);
        end
    endtask

    task automatic test_misalign();
        int idx;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 40 && deliv_log.size() < 2; i++) @(negedge clk);
        cyc();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h202;
        @(negedge clk);
        #1;
        idx = hs_log.size();
        cyc();
        PCSrcE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (MisalignF !== 1'b1) begin
            n_errors++;
            $display("FAIL misalign_pulse: got %0b, required 1", MisalignF);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (MisalignF !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_width: got %0b, required 0", MisalignF);
        end
        for (int i = 0; i < 20 && hs_log.size() <= idx; i++) @(negedge clk);
        #1;
        got = (hs_log.size() > idx) ? hs_log[idx] : 32'hDEAD_DEAD;
        n_checks++;
        if (got !== 32'h200) begin
            n_errors++;
            $display("FAIL misalign_req: addr=%h, required 00000200", got);
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] saved;
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 40 && deliv_log.size() < 2; i++) @(negedge clk);
        cyc();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) @(negedge clk);
        saved = imem_req_addr;
        #1;
        want = (hs_log.size() > 0) ? hs_log[hs_log.size() - 1] + 32'd4 : 32'hDEAD_DEAD;
        n_checks++;
        if (imem_req_valid !== 1'b1 || saved !== want) begin
            n_errors++;
            $display("FAIL ready_low_req: valid=%0b addr=%h, required 1 %h", imem_req_valid, saved, want);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== saved || InstrValidF !== 1'b0 || InstrF !== NOP) begin
                n_errors++;
                $display("FAIL ready_low%0d: req=%0b addr=%h valid=%0b instr=%h, required 1 %h 0 %h", i, imem_req_valid, imem_req_addr, InstrValidF, InstrF, saved, NOP);
            end
        end
        cyc();
        imem_req_ready = 1'b1;
    endtask

    task automatic test_reset_wrap();
        bit found = 0;
        logic [31:0] got;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 40 && deliv_log.size() < 1; i++) @(negedge clk);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) found = 1;
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (!found || imem_req_valid !== 1'b0 || PCF === 32'h0) begin
            n_errors++;
            $display("FAIL wrap_wait_state: found=%0b req_valid=%0b pc=%h, required 1 0 nonzero", found, imem_req_valid, PCF);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (InstrF !== NOP || PCF !== 32'h0 || PCPlus4F !== 32'h4 || InstrValidF !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: instr=%h pc=%h pc4=%h valid=%0b req=%0b", InstrF, PCF, PCPlus4F, InstrValidF, imem_req_valid);
        end
        imem_req_ready = 1'b0;
        mem_lat        = 1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5 && imem_req_valid !== 1'b1; i++) @(negedge clk);
        cyc();
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        cyc();
        PCSrcE         = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 40 && deliv_log.size() < 2; i++) @(negedge clk);
        #1;
        got = (hs_log.size() > 1) ? hs_log[1] : 32'hDEAD_DEAD;
        n_checks++;
        if (hs_log.size() < 2 || hs_log[0] !== 32'hFFFF_FFFC || got !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_req: second request addr=%h, required 00000000 after fffffffc", got);
        end
        got = (deliv_log.size() > 1) ? deliv_log[1] : 32'hDEAD_DEAD;
        n_checks++;
        if (deliv_log.size() < 2 || deliv_log[0] !== 32'hFFFF_FFFC || got !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_deliver: second delivery pc=%h, required 00000000 after fffffffc", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            StallF         = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            PCSrcE         = ($urandom_range(0, 29) == 0);
            PCTargetE      = $urandom;
        end
        cyc();
        StallF         = 1'b0;
        PCSrcE         = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        n_checks++;
        if (deliv_log.size() < 100) begin
            n_errors++;
            $display("FAIL random_progress: %0d deliveries, required at least 100", deliv_log.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_ready_low();
        test_reset_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
